// File: rtl/pe_pkg.sv
// Shared widths, control encodings and the lane arithmetic helper for the
// 16-lane processing element.
package pe_pkg;

    localparam int DW    = 32;
    localparam int LANES = 16;

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    localparam logic [1:0] GB_NONE = 2'b00;
    localparam logic [1:0] GB_TO_B = 2'b01;
    localparam logic [1:0] GB_FWD  = 2'b10;
    localparam logic [1:0] GB_TO_A = 2'b11;

    localparam logic [1:0] AD_HOLD   = 2'b00;
    localparam logic [1:0] AD_BYPASS = 2'b01;
    localparam logic [1:0] AD_SUM    = 2'b10;

    localparam logic [DW-1:0] ZERO_W = {DW{1'b0}};

    // Unsigned modulo-2^DW lane operation; multiply keeps the low DW bits.
    function automatic logic [DW-1:0] cu_op(input logic [1:0]    sel,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (sel)
            OP_SUB:  r = a - b;
            OP_ADD:  r = a + b;
            OP_PASS: r = a;
            OP_MUL:  r = a * b;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pe_cu.sv
// One compute lane: operand registers with feedback overrides, result,
// frozen snapshot for feedback, and the forward register to the output stage.
module pe_cu
    import pe_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [1:0]    sel_cu,
    input  logic [1:0]    sel_go_back,
    input  logic          is_save,
    output logic [DW-1:0] st
);

    logic [DW-1:0] op_a_r, op_b_r, cu_out_r, save_r, st_r;
    logic          ovr_a_r, ovr_b_r;
    logic [DW-1:0] op_a_s, op_b_s;
    logic          ovr_a_s, ovr_b_s;

    // Next operand values: ports unless overridden, snapshot on feedback loads.
    always_comb begin
        op_a_s  = op_a_r;
        op_b_s  = op_b_r;
        ovr_a_s = ovr_a_r;
        ovr_b_s = ovr_b_r;
        case (sel_go_back)
            GB_NONE: begin
                ovr_a_s = 1'b0;
                ovr_b_s = 1'b0;
                op_a_s  = ovr_a_r ? op_a_r : in_a;
                op_b_s  = ovr_b_r ? op_b_r : in_b;
            end
            GB_TO_B: begin
                op_a_s = ovr_a_r ? op_a_r : in_a;
                if (is_save) begin
                    op_b_s  = save_r;
                    ovr_b_s = 1'b1;
                end else begin
                    op_b_s  = op_b_r;
                end
            end
            GB_TO_A: begin
                op_b_s = ovr_b_r ? op_b_r : in_b;
                if (is_save) begin
                    op_a_s  = save_r;
                    ovr_a_s = 1'b1;
                end else begin
                    op_a_s  = op_a_r;
                end
            end
            GB_FWD: begin
                op_a_s = ovr_a_r ? op_a_r : in_a;
                op_b_s = ovr_b_r ? op_b_r : in_b;
            end
            default: begin
                op_a_s = op_a_r;
                op_b_s = op_b_r;
            end
        endcase
    end

    // Lane pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r   <= ZERO_W;
            op_b_r   <= ZERO_W;
            ovr_a_r  <= 1'b0;
            ovr_b_r  <= 1'b0;
            cu_out_r <= ZERO_W;
            save_r   <= ZERO_W;
            st_r     <= ZERO_W;
        end else begin
            op_a_r   <= op_a_s;
            op_b_r   <= op_b_s;
            ovr_a_r  <= ovr_a_s;
            ovr_b_r  <= ovr_b_s;
            cu_out_r <= cu_op(sel_cu, op_a_r, op_b_r);
            // Snapshot freezes so a feedback load never sees a moving result.
            if (is_save) begin
                save_r <= save_r;
            end else begin
                save_r <= cu_out_r;
            end
            if (sel_go_back == GB_FWD) begin
                st_r <= cu_out_r;
            end else begin
                st_r <= st_r;
            end
        end
    end

    assign st = st_r;

endmodule

// File: rtl/pe.sv
// 16-lane processing element: per-lane compute units feeding either a
// registered adder-tree total or registered per-lane bypass outputs.
module pe
    import pe_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] In0,
    input  logic [DW-1:0] In1,
    input  logic [DW-1:0] In2,
    input  logic [DW-1:0] In3,
    input  logic [DW-1:0] In4,
    input  logic [DW-1:0] In5,
    input  logic [DW-1:0] In6,
    input  logic [DW-1:0] In7,
    input  logic [DW-1:0] In8,
    input  logic [DW-1:0] In9,
    input  logic [DW-1:0] In10,
    input  logic [DW-1:0] In11,
    input  logic [DW-1:0] In12,
    input  logic [DW-1:0] In13,
    input  logic [DW-1:0] In14,
    input  logic [DW-1:0] In15,
    input  logic [DW-1:0] Par0,
    input  logic [DW-1:0] Par1,
    input  logic [DW-1:0] Par2,
    input  logic [DW-1:0] Par3,
    input  logic [DW-1:0] Par4,
    input  logic [DW-1:0] Par5,
    input  logic [DW-1:0] Par6,
    input  logic [DW-1:0] Par7,
    input  logic [DW-1:0] Par8,
    input  logic [DW-1:0] Par9,
    input  logic [DW-1:0] Par10,
    input  logic [DW-1:0] Par11,
    input  logic [DW-1:0] Par12,
    input  logic [DW-1:0] Par13,
    input  logic [DW-1:0] Par14,
    input  logic [DW-1:0] Par15,
    input  logic [1:0]    Sel_cu,
    input  logic [1:0]    Sel_cu_go_back,
    input  logic [1:0]    Sel_adder,
    input  logic          Is_save_cu_out,
    output logic [DW-1:0] Out_total,
    output logic [DW-1:0] Out0,
    output logic [DW-1:0] Out1,
    output logic [DW-1:0] Out2,
    output logic [DW-1:0] Out3,
    output logic [DW-1:0] Out4,
    output logic [DW-1:0] Out5,
    output logic [DW-1:0] Out6,
    output logic [DW-1:0] Out7,
    output logic [DW-1:0] Out8,
    output logic [DW-1:0] Out9,
    output logic [DW-1:0] Out10,
    output logic [DW-1:0] Out11,
    output logic [DW-1:0] Out12,
    output logic [DW-1:0] Out13,
    output logic [DW-1:0] Out14,
    output logic [DW-1:0] Out15
);

    logic [DW-1:0] in_s   [LANES];
    logic [DW-1:0] par_s  [LANES];
    logic [DW-1:0] st_s   [LANES];
    logic [DW-1:0] out_r  [LANES];
    logic [DW-1:0] lvl1_s [8];
    logic [DW-1:0] lvl2_s [4];
    logic [DW-1:0] lvl3_s [2];
    logic [DW-1:0] sum_s;
    logic [DW-1:0] total_r;

    assign in_s[0]  = In0;   assign par_s[0]  = Par0;
    assign in_s[1]  = In1;   assign par_s[1]  = Par1;
    assign in_s[2]  = In2;   assign par_s[2]  = Par2;
    assign in_s[3]  = In3;   assign par_s[3]  = Par3;
    assign in_s[4]  = In4;   assign par_s[4]  = Par4;
    assign in_s[5]  = In5;   assign par_s[5]  = Par5;
    assign in_s[6]  = In6;   assign par_s[6]  = Par6;
    assign in_s[7]  = In7;   assign par_s[7]  = Par7;
    assign in_s[8]  = In8;   assign par_s[8]  = Par8;
    assign in_s[9]  = In9;   assign par_s[9]  = Par9;
    assign in_s[10] = In10;  assign par_s[10] = Par10;
    assign in_s[11] = In11;  assign par_s[11] = Par11;
    assign in_s[12] = In12;  assign par_s[12] = Par12;
    assign in_s[13] = In13;  assign par_s[13] = Par13;
    assign in_s[14] = In14;  assign par_s[14] = Par14;
    assign in_s[15] = In15;  assign par_s[15] = Par15;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pe_cu u_cu (
            .clk         (clk),
            .rst_n       (rst),
            .in_a        (in_s[g]),
            .in_b        (par_s[g]),
            .sel_cu      (Sel_cu),
            .sel_go_back (Sel_cu_go_back),
            .is_save     (Is_save_cu_out),
            .st          (st_s[g])
        );
    end

    // Four-level binary reduction of the forward registers, wrapping at DW bits.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl1_s[i] = st_s[2*i] + st_s[2*i+1];
        end
        for (int i = 0; i < 4; i++) begin
            lvl2_s[i] = lvl1_s[2*i] + lvl1_s[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            lvl3_s[i] = lvl2_s[2*i] + lvl2_s[2*i+1];
        end
        sum_s = lvl3_s[0] + lvl3_s[1];
    end

    // Output stage: total or per-lane bypass, everything else holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_r <= ZERO_W;
            for (int i = 0; i < LANES; i++) begin
                out_r[i] <= ZERO_W;
            end
        end else begin
            case (Sel_adder)
                AD_SUM: begin
                    total_r <= sum_s;
                end
                AD_BYPASS: begin
                    for (int i = 0; i < LANES; i++) begin
                        out_r[i] <= st_s[i];
                    end
                end
                AD_HOLD: begin
                    total_r <= total_r;
                end
                default: begin
                    total_r <= total_r;
                end
            endcase
        end
    end

    assign Out_total = total_r;
    assign Out0  = out_r[0];   assign Out1  = out_r[1];
    assign Out2  = out_r[2];   assign Out3  = out_r[3];
    assign Out4  = out_r[4];   assign Out5  = out_r[5];
    assign Out6  = out_r[6];   assign Out7  = out_r[7];
    assign Out8  = out_r[8];   assign Out9  = out_r[9];
    assign Out10 = out_r[10];  assign Out11 = out_r[11];
    assign Out12 = out_r[12];  assign Out13 = out_r[13];
    assign Out14 = out_r[14];  assign Out15 = out_r[15];

endmodule

// File: tb/tb_pe.sv
// Directed-plus-random bench for pe; expectations come from plain arithmetic
// over the lane operands, not from any model of the pipeline registers.
module tb_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_v  [16];
    logic [31:0] par_v [16];
    logic [1:0]  sel_cu, gb, sel_adder;
    logic        is_save;
    logic [31:0] out_total;
    logic [31:0] out_w [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe dut (
        .clk(clk), .rst(rst),
        .In0(in_v[0]),   .In1(in_v[1]),   .In2(in_v[2]),   .In3(in_v[3]),
        .In4(in_v[4]),   .In5(in_v[5]),   .In6(in_v[6]),   .In7(in_v[7]),
        .In8(in_v[8]),   .In9(in_v[9]),   .In10(in_v[10]), .In11(in_v[11]),
        .In12(in_v[12]), .In13(in_v[13]), .In14(in_v[14]), .In15(in_v[15]),
        .Par0(par_v[0]),   .Par1(par_v[1]),   .Par2(par_v[2]),   .Par3(par_v[3]),
        .Par4(par_v[4]),   .Par5(par_v[5]),   .Par6(par_v[6]),   .Par7(par_v[7]),
        .Par8(par_v[8]),   .Par9(par_v[9]),   .Par10(par_v[10]), .Par11(par_v[11]),
        .Par12(par_v[12]), .Par13(par_v[13]), .Par14(par_v[14]), .Par15(par_v[15]),
        .Sel_cu(sel_cu), .Sel_cu_go_back(gb), .Sel_adder(sel_adder),
        .Is_save_cu_out(is_save),
        .Out_total(out_total),
        .Out0(out_w[0]),   .Out1(out_w[1]),   .Out2(out_w[2]),   .Out3(out_w[3]),
        .Out4(out_w[4]),   .Out5(out_w[5]),   .Out6(out_w[6]),   .Out7(out_w[7]),
        .Out8(out_w[8]),   .Out9(out_w[9]),   .Out10(out_w[10]), .Out11(out_w[11]),
        .Out12(out_w[12]), .Out13(out_w[13]), .Out14(out_w[14]), .Out15(out_w[15])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'd0:    return a - b;
            2'd1:    return a + b;
            2'd2:    return a;
            default: begin
                p = 64'(a) * 64'(b);
                return p[31:0];
            end
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_dot_inputs();
        for (int i = 0; i < 16; i++) begin
            in_v[i]  = 32'd1;
            par_v[i] = 32'(i + 1);
        end
    endtask

    // In=1, Par=1..16 multiplied, forwarded, then reduced.
    task automatic run_dot(input logic [1:0] gb_first, input string tag);
        set_dot_inputs();
        sel_cu = 2'b11; gb = gb_first; sel_adder = 2'b00; is_save = 1'b0;
        step(20);
        gb = 2'b10;
        step(20);
        sel_adder = 2'b10;
        step(20);
        check(tag, out_total, 32'h0000_0088);
    endtask

    // Squared-distance setup through both feedback loads; returns the model total.
    task automatic sq_prep(output logic [31:0] exp_total);
        logic [31:0] d;
        exp_total = 32'd0;
        for (int i = 0; i < 16; i++) begin
            d = ref_op(2'd0, in_v[i], par_v[i]);
            exp_total = exp_total + ref_op(2'd3, d, d);
        end
        sel_cu = 2'b00; gb = 2'b00; is_save = 1'b0; sel_adder = 2'b00;
        step(20);
        is_save = 1'b1;
        step(5);
        gb = 2'b01;
        step(5);
        gb = 2'b11;
        step(5);
        // Both operands are overridden now, so port changes must be ignored.
        for (int i = 0; i < 16; i++) begin
            in_v[i]  = $urandom;
            par_v[i] = $urandom;
        end
        is_save = 1'b0;
        sel_cu  = 2'b11;
        step(5);
        gb = 2'b10;
        step(20);
    endtask

    initial begin
        logic [31:0] exp_t;
        logic [31:0] exp_lane [16];
        logic [1:0]  op;

        rst = 1'b0; sel_cu = 2'b00; gb = 2'b00; sel_adder = 2'b00; is_save = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_v[i] = 32'd0; par_v[i] = 32'd0;
        end
        #2;
        check("reset_total", out_total, 32'd0);
        check("reset_out0", out_w[0], 32'd0);
        step(3);
        check("reset_out15", out_w[15], 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_dot(2'b00, "dot_product");

        // Bypass multiply; total must hold at the previous reduction.
        for (int i = 0; i < 16; i++) begin
            in_v[i] = 32'(i + 1); par_v[i] = 32'd2;
        end
        sel_cu = 2'b11; gb = 2'b10; sel_adder = 2'b00;
        step(20);
        sel_adder = 2'b01;
        step(20);
        for (int i = 0; i < 16; i++) check($sformatf("bypass_mul_%0d", i), out_w[i], 32'(2 * (i + 1)));
        check("bypass_total_hold", out_total, 32'h0000_0088);

        sel_adder = 2'b00;
        for (int i = 0; i < 16; i++) par_v[i] = 32'd3;
        step(20);
        check("hold_out5", out_w[5], 32'd12);
        check("hold_total", out_total, 32'h0000_0088);

        // Wrap-around at 32 bits.
        for (int i = 0; i < 16; i++) begin
            in_v[i] = 32'hFFFF_FFFF; par_v[i] = 32'd2;
        end
        sel_cu = 2'b01; gb = 2'b10; sel_adder = 2'b01;
        step(20);
        check("wrap_add_0", out_w[0], 32'h0000_0001);
        check("wrap_add_15", out_w[15], 32'h0000_0001);
        sel_cu = 2'b11;
        step(20);
        check("wrap_mul_7", out_w[7], 32'hFFFF_FFFE);
        sel_adder = 2'b10;
        step(10);
        check("wrap_sum", out_total, 32'hFFFF_FFE0);
        for (int i = 0; i < 16; i++) begin
            in_v[i] = 32'd1; par_v[i] = 32'd16;
        end
        sel_cu = 2'b00; sel_adder = 2'b01;
        step(20);
        check("wrap_sub", out_w[3], 32'hFFFF_FFF1);

        // Four-clock input-to-output latency.
        for (int i = 0; i < 16; i++) begin
            in_v[i] = 32'd0; par_v[i] = 32'd0;
        end
        sel_cu = 2'b10; gb = 2'b10; sel_adder = 2'b01;
        step(20);
        in_v[0] = 32'h0000_1234;
        step(3);
        check("latency_3clk_old", out_w[0], 32'd0);
        step(1);
        check("latency_4clk_new", out_w[0], 32'h0000_1234);

        // Squared distance via feedback, then overrides cleared.
        set_dot_inputs();
        sq_prep(exp_t);
        sel_adder = 2'b10;
        step(20);
        check("sqdist_model", exp_t, 32'h0000_04D8);
        check("sqdist", out_total, 32'h0000_04D8);
        gb = 2'b00;
        step(5);
        run_dot(2'b00, "override_clear_dot");

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                in_v[i] = $urandom_range(0, 65535); par_v[i] = $urandom_range(0, 65535);
            end
            sq_prep(exp_t);
            sel_adder = 2'b10;
            step(20);
            check($sformatf("rand_sqdist_%0d", k), out_total, exp_t);
            gb = 2'b00;
            step(5);
        end

        // Random op and operands checked lane-wise and reduced.
        for (int k = 0; k < 4; k++) begin
            op = 2'($urandom_range(0, 3));
            exp_t = 32'd0;
            for (int i = 0; i < 16; i++) begin
                in_v[i] = $urandom; par_v[i] = $urandom;
                exp_lane[i] = ref_op(op, in_v[i], par_v[i]);
                exp_t = exp_t + exp_lane[i];
            end
            sel_cu = op; gb = 2'b10; sel_adder = 2'b01;
            step(20);
            for (int i = 0; i < 16; i++) check($sformatf("rand_lane_%0d_%0d", k, i), out_w[i], exp_lane[i]);
            sel_adder = 2'b10;
            step(10);
            check($sformatf("rand_total_%0d", k), out_total, exp_t);
        end

        // Reset in the middle of a squared-distance run.
        set_dot_inputs();
        sq_prep(exp_t);
        sel_adder = 2'b00;
        step(3);
        #3;
        rst = 1'b0;
        #1;
        check("midreset_total", out_total, 32'd0);
        for (int i = 0; i < 16; i++) check($sformatf("midreset_out_%0d", i), out_w[i], 32'd0);
        gb = 2'b10; sel_cu = 2'b11; is_save = 1'b0;
        set_dot_inputs();
        @(negedge clk);
        rst = 1'b1;
        run_dot(2'b10, "post_reset_dot");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe.md
Name: pe

Overview:
- 16-lane processing element for the accelerator datapath.
- Each lane is a compute unit (CU) performing add, subtract, pass or multiply on an input word and a parameter word.
- A lane result can be fed back into its own operands, or forwarded to an output stage.
- The output stage either reduces all 16 lanes through an adder tree into one total, or bypasses to per-lane outputs.
- Used for dot products (LR/SVM/DNN) and squared distances (k-NN/k-Means).

Parameters:
- LANES, 16, number of CU lanes; fixed at 16 because the ports are enumerated.
- DW, 32, data width of every data port and register.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- In0..In15  in  32 each  per-lane input operand A
- Par0..Par15  in  32 each  per-lane parameter operand B
- Sel_cu  in  2  CU op: 00 = A-B, 01 = A+B, 10 = pass A, 11 = A*B
- Sel_cu_go_back  in  2  00 = none/clear overrides, 01 = feed back into B, 10 = forward to output stage, 11 = feed back into A
- Sel_adder  in  2  00 = hold, 01 = bypass to per-lane outputs, 10 = adder-tree reduce, 11 = hold (reserved)
- Is_save_cu_out  in  1  1 = freeze the CU-result snapshot and enable feedback loads
- Out_total  out  32  adder-tree sum
- Out0..Out15  out  32 each  per-lane bypass results
- Interface fixed: one clock; reset asynchronous, active-low.

Behaviour:
- Reset (rst=0, async): all registers, outputs and override flags go to 0.
- Arithmetic:
  - Unsigned, modulo 2^32.
  - Multiply keeps the low 32 bits.
  - Subtract is two's-complement wrap (1-16 = 0xFFFFFFF1).
  - Adder-tree sum wraps at 32 bits.
- Operand registers opA[i], opB[i], updated every clk:
  - If ovrA[i]=0, opA <= In[i]; if ovrB[i]=0, opB <= Par[i].
  - Sel_cu_go_back=01 and Is_save_cu_out=1: opB <= save[i], ovrB <= 1.
  - Sel_cu_go_back=11 and Is_save_cu_out=1: opA <= save[i], ovrA <= 1.
  - Sel_cu_go_back=01/11 with Is_save_cu_out=0: the targeted operand holds.
  - Sel_cu_go_back=00: clears ovrA and ovrB, so operands follow the inputs again.
  - Sel_cu_go_back=10: leaves overrides unchanged.
- CU result register: cu_out[i] <= op(opA[i], opB[i]) every clk.
- Snapshot register:
  - save[i] <= cu_out[i] while Is_save_cu_out=0.
  - Holds while Is_save_cu_out=1, so feedback never chases a changing result.
- Forward register: st[i] <= cu_out[i] when Sel_cu_go_back=10; otherwise holds.
- Output stage, registered:
  - Sel_adder=10: Out_total <= sum of st[0..15]; Out0..15 hold.
  - Sel_adder=01: Out[i] <= st[i]; Out_total holds.
  - Sel_adder=00 or 11: all outputs hold.
- Latency with controls stable: input change -> opA/opB (1 clk) -> cu_out (2) -> st (3) -> Out* (4).
- Simultaneous events:
  - A feedback load and a snapshot freeze in the same cycle use the old save value; the freeze takes effect on the next edge.
  - Controls changing mid-operation take effect on the next edge; there is no handshake.
- Reset mid-operation clears everything immediately, including overrides.

Decomposition:
- Package pe_pkg:
  - DW and LANES.
  - Localparams for Sel_cu opcodes (OP_SUB, OP_ADD, OP_PASS, OP_MUL).
  - Localparams for go-back codes (GB_NONE, GB_TO_B, GB_FWD, GB_TO_A).
  - Localparams for adder codes (AD_HOLD, AD_BYPASS, AD_SUM).
- One sub-module, pe_cu: a single lane holding opA/opB, ovrA/ovrB, cu_out, save and st. It is instantiated 16 times.
- The top level holds the 16-input adder tree (4 combinational levels, registered at the output) and the per-lane output registers.

Test Plan:
1. Dot product: In=1, Par=1..16; Sel_cu=11, then Sel_cu_go_back=10, then Sel_adder=10, 20 clks apart -> Out_total = 0x88 (136).
2. Bypass multiply: In=1..16, Par=2; Sel_cu=11, Sel_cu_go_back=10, Sel_adder=01 -> Out0..Out15 = 0x02, 0x04, ..., 0x20; Out_total unchanged.
3. Squared distance: In=1, Par=1..16; Sel_cu=00; then Is_save_cu_out=1; Sel_cu_go_back=01; then 11; then Is_save_cu_out=0; Sel_cu=11; Sel_cu_go_back=10; Sel_adder=10 -> Out_total = 0x4D8 (1240).
4. Wrap: In=0xFFFFFFFF, Par=2, Sel_cu=01, forward, bypass -> Out[i] = 0x00000001; with Sel_cu=11 -> 0xFFFFFFFE.
5. Override clear: after scenario 3, set Sel_cu_go_back=00 with new In/Par -> operands follow the ports again; the dot product of scenario 1 reproduces 0x88.
6. Reset mid-run: assert rst=0 during scenario 3 -> all Out* = 0 asynchronously and overrides cleared; release, rerun scenario 1 -> 0x88.
